// File: rtl/instruction_fetch.sv
// Instruction fetch stage with a registered-memory slot tracker, a redirect path and a HALT stop.
// Zero-cycle memory enable; instruction k reaches IF/ID on the second advancing edge; decode stall or pause holds all state.
module instruction_fetch #(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = 128
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic                  i_stall,
   input  logic                  i_jump,
   input  logic                  i_branch_taken,
   input  logic [DATA_WIDTH-1:0] i_jump_target,
   input  logic [DATA_WIDTH-1:0] i_branch_target,
   input  logic [DATA_WIDTH-1:0] i_instruction,
   output logic [DATA_WIDTH-1:0] o_pc,
   output logic                  o_imem_valid,
   output logic [DATA_WIDTH-1:0] o_if_id_instruction,
   output logic [DATA_WIDTH-1:0] o_if_id_pc_plus1,
   output logic                  o_if_id_valid,
   output logic                  o_halted
);

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(DATA_DEPTH);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] slot_pc_q, slot_pc_d;
   logic                  slot_vld_q, slot_vld_d;
   logic [DATA_WIDTH-1:0] ifid_ins_q, ifid_ins_d;
   logic [DATA_WIDTH-1:0] ifid_pc1_q, ifid_pc1_d;
   logic                  ifid_vld_q, ifid_vld_d;

   logic                  run, halt_now, redirect, advance;
   logic [DATA_WIDTH-1:0] target;

   assign run      = (state_q == RUN);
   assign halt_now = run & slot_vld_q & (i_instruction[31:26] == 6'b111111);
   assign redirect = run & i_valid & (i_jump | i_branch_taken);
   assign advance  = run & i_valid & ~i_stall & ~redirect & ~halt_now;
   assign target   = i_jump ? i_jump_target : i_branch_target;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      slot_pc_d  = slot_pc_q;
      slot_vld_d = slot_vld_q;
      ifid_ins_d = ifid_ins_q;
      ifid_pc1_d = ifid_pc1_q;
      ifid_vld_d = ifid_vld_q;
      case (state_q)
         IDLE: begin
            if (i_valid) state_d = RUN;
         end
         RUN: begin
            // Redirect wins over stall and over a HALT word sitting in the slot.
            if (redirect) begin
               pc_d       = target % DEPTH_W;
               slot_vld_d = 1'b0;
               ifid_vld_d = 1'b0;
            end else if (halt_now && i_valid && !i_stall) begin
               ifid_ins_d = i_instruction;
               ifid_pc1_d = slot_pc_q + 1'b1;
               ifid_vld_d = 1'b1;
               slot_vld_d = 1'b0;
               state_d    = HALTED;
            end else if (advance) begin
               pc_d       = (pc_q >= DEPTH_W - 1'b1) ? '0 : pc_q + 1'b1;
               slot_pc_d  = pc_q;
               slot_vld_d = 1'b1;
               ifid_ins_d = i_instruction;
               ifid_pc1_d = slot_pc_q + 1'b1;
               ifid_vld_d = slot_vld_q;
            end
         end
         HALTED: begin
            if (!i_stall) ifid_vld_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         slot_pc_q  <= '0;
         slot_vld_q <= 1'b0;
         ifid_ins_q <= '0;
         ifid_pc1_q <= '0;
         ifid_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         slot_pc_q  <= slot_pc_d;
         slot_vld_q <= slot_vld_d;
         ifid_ins_q <= ifid_ins_d;
         ifid_pc1_q <= ifid_pc1_d;
         ifid_vld_q <= ifid_vld_d;
      end
   end

   assign o_pc                = pc_q;
   assign o_imem_valid        = advance & ~i_reset;
   assign o_if_id_instruction = ifid_ins_q;
   assign o_if_id_pc_plus1    = ifid_pc1_q;
   assign o_if_id_valid       = ifid_vld_q;
   assign o_halted            = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: registered instruction memory model, vector table and hand-built corner sequences.
module tb_instruction_fetch;

   typedef struct {
      logic        r, v, s, j, b;
      logic [31:0] jt, bt;
      logic        imv;
      logic [31:0] pc;
      logic        ifv;
      logic [31:0] ins, p1;
      logic        hlt;
      bit          ck;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, vld, stall, jmp, br;
   logic [31:0] jt, bt;
   logic [31:0] mem_q;
   logic [31:0] pc, ifid_ins, ifid_p1;
   logic        imv, ifid_vld, halted;

   logic [31:0] mem [128];
   vec_t        tbl [$];
   vec_t        sb  [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Registered-read instruction memory driven by the fetch enable.
   always @(posedge clk) begin
      if (rst) mem_q <= 32'h0;
      else if (imv) mem_q <= mem[pc[6:0]];
   end

   instruction_fetch dut (
      .i_clk               (clk),
      .i_reset             (rst),
      .i_valid             (vld),
      .i_stall             (stall),
      .i_jump              (jmp),
      .i_branch_taken      (br),
      .i_jump_target       (jt),
      .i_branch_target     (bt),
      .i_instruction       (mem_q),
      .o_pc                (pc),
      .o_imem_valid        (imv),
      .o_if_id_instruction (ifid_ins),
      .o_if_id_pc_plus1    (ifid_p1),
      .o_if_id_valid       (ifid_vld),
      .o_halted            (halted)
   );

   function automatic vec_t mk(input logic r, v, s, j, b, input logic [31:0] t_j, t_b,
                               input logic e_imv, input logic [31:0] e_pc, input logic e_ifv,
                               input logic [31:0] e_ins, e_p1, input logic e_hlt, input bit ck);
      vec_t t;
      t.r = r; t.v = v; t.s = s; t.j = j; t.b = b; t.jt = t_j; t.bt = t_b;
      t.imv = e_imv; t.pc = e_pc; t.ifv = e_ifv; t.ins = e_ins; t.p1 = e_p1;
      t.hlt = e_hlt; t.ck = ck;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Called at a falling edge: drive, check the enable before the edge, then check registered outputs after it.
   task automatic apply(input string tag, input int idx, input vec_t t);
      vec_t e;
      string nm;
      nm = $sformatf("%s[%0d]", tag, idx);
      rst = t.r; vld = t.v; stall = t.s; jmp = t.j; br = t.b; jt = t.jt; bt = t.bt;
      #1;
      chk({nm, ".imem_valid"}, 32'(imv), 32'(t.imv));
      sb.push_back(t);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk({nm, ".pc"}, pc, e.pc);
      chk({nm, ".if_id_valid"}, 32'(ifid_vld), 32'(e.ifv));
      chk({nm, ".halted"}, 32'(halted), 32'(e.hlt));
      if (e.ck) begin
         chk({nm, ".if_id_instr"}, ifid_ins, e.ins);
         chk({nm, ".if_id_pc_plus1"}, ifid_p1, e.p1);
      end
   endtask

   initial begin
      rst = 1'b1; vld = 1'b0; stall = 1'b0; jmp = 1'b0; br = 1'b0; jt = '0; bt = '0;
      for (int k = 0; k < 128; k++) mem[k] = 32'h100 + k;

      // r v s j b  jt      bt       imv pc      ifv ins      p1      hlt ck
      tbl.push_back(mk(1,0,0,0,0, 0,      0,       0, 0,      0, 0,       0,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       0, 0,      0, 0,       0,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 1,      0, 0,       1,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 2,      1, 'h100,   1,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 3,      1, 'h101,   2,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 4,      1, 'h102,   3,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 5,      1, 'h103,   4,      0, 1));
      tbl.push_back(mk(0,1,1,0,0, 0,      0,       0, 5,      1, 'h103,   4,      0, 1));
      tbl.push_back(mk(0,1,1,0,0, 0,      0,       0, 5,      1, 'h103,   4,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 6,      1, 'h104,   5,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 7,      1, 'h105,   6,      0, 1));
      tbl.push_back(mk(0,0,0,0,0, 0,      0,       0, 7,      1, 'h105,   6,      0, 1));
      tbl.push_back(mk(0,1,1,0,1, 0,      'h20,    0, 'h20,   0, 'h105,   6,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 'h21,   0, 'h106,   7,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 'h22,   1, 'h120,   'h21,   0, 1));
      tbl.push_back(mk(0,1,0,1,1, 'h40,   'h30,    0, 'h40,   0, 'h120,   'h21,   0, 1));
      tbl.push_back(mk(0,1,0,1,0, 'h185,  0,       0, 5,      0, 'h120,   'h21,   0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 6,      0, 'h121,   'h22,   0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 7,      1, 'h105,   6,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 8,      1, 'h106,   7,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 9,      1, 'h107,   8,      0, 1));
      tbl.push_back(mk(1,1,0,0,1, 0,      'h33,    0, 0,      0, 0,       0,      0, 1));
      tbl.push_back(mk(0,0,0,1,0, 'h44,   0,       0, 0,      0, 0,       0,      0, 1));
      tbl.push_back(mk(0,1,0,1,0, 'h44,   0,       0, 0,      0, 0,       0,      0, 1));
      tbl.push_back(mk(0,1,0,0,0, 0,      0,       1, 1,      0, 0,       1,      0, 1));

      foreach (tbl[i]) apply("table", i, tbl[i]);

      // HALT word at address 3, held first by a stall and a pause.
      mem[3] = 32'hFC00_0000;
      apply("halt", 0,  mk(1,0,0,0,0, 0,0,    0, 0, 0, 0,            0, 0, 1));
      apply("halt", 1,  mk(0,1,0,0,0, 0,0,    0, 0, 0, 0,            0, 0, 1));
      apply("halt", 2,  mk(0,1,0,0,0, 0,0,    1, 1, 0, 0,            1, 0, 1));
      apply("halt", 3,  mk(0,1,0,0,0, 0,0,    1, 2, 1, 'h100,        1, 0, 1));
      apply("halt", 4,  mk(0,1,0,0,0, 0,0,    1, 3, 1, 'h101,        2, 0, 1));
      apply("halt", 5,  mk(0,1,0,0,0, 0,0,    1, 4, 1, 'h102,        3, 0, 1));
      apply("halt", 6,  mk(0,1,1,0,0, 0,0,    0, 4, 1, 'h102,        3, 0, 1));
      apply("halt", 7,  mk(0,0,0,0,0, 0,0,    0, 4, 1, 'h102,        3, 0, 1));
      apply("halt", 8,  mk(0,1,0,0,0, 0,0,    0, 4, 1, 32'hFC000000, 4, 1, 1));
      apply("halt", 9,  mk(0,1,1,0,0, 0,0,    0, 4, 1, 32'hFC000000, 4, 1, 1));
      apply("halt", 10, mk(0,1,0,1,0, 'h10,0, 0, 4, 0, 32'hFC000000, 4, 1, 1));
      apply("halt", 11, mk(0,1,0,0,1, 0,'h20, 0, 4, 0, 32'hFC000000, 4, 1, 1));
      mem[3] = 32'h103;

      // Walk the whole address space and wrap from 127 back to 0.
      apply("wrap", 0, mk(1,0,0,0,0, 0,0, 0, 0, 0, 0, 0, 0, 1));
      apply("wrap", 1, mk(0,1,0,0,0, 0,0, 0, 0, 0, 0, 0, 0, 1));
      for (int n = 1; n <= 128; n++) begin
         apply("wrap", n + 1, mk(0,1,0,0,0, 0,0, 1, 32'(n % 128), (n >= 2),
                                 (n >= 2) ? 32'h100 + 32'(n - 2) : 32'h0,
                                 (n >= 2) ? 32'(n - 1) : 32'h1, 0, 1));
      end

      // Jump issued while a HALT word sits in the slot squashes the halt.
      mem[14] = 32'hFC00_0000;
      apply("over", 0, mk(0,1,0,1,0, 'h0E,0, 0, 'h0E, 0, 0,      0,     0, 0));
      apply("over", 1, mk(0,1,0,0,0, 0,0,    1, 'h0F, 0, 0,      0,     0, 0));
      apply("over", 2, mk(0,1,0,1,0, 'h10,0, 0, 'h10, 0, 0,      0,     0, 0));
      apply("over", 3, mk(0,1,0,0,0, 0,0,    1, 'h11, 0, 0,      0,     0, 0));
      apply("over", 4, mk(0,1,0,0,0, 0,0,    1, 'h12, 1, 'h110,  'h11,  0, 1));

      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
